// File: rtl/program_memory_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : program_memory_unit_if
// Description : CPU read channel (4-phase req/ack) and byte-stream program-load
//               channel of the program memory unit.
//               master : CPU core / board loader side (drives requests, bytes)
//               slave  : program memory unit side (drives ack, data, ready)
//   rd_req   CPU read request level        rd_addr  read address
//   rd_data  read data (valid with ack)    rd_ack   read acknowledge
//   rd_err   address out of range          ld_start begin load at address 0
//   ld_valid ld_data holds a byte          ld_data  byte to write
//   ld_ready unit accepts a byte           ld_done  sticky load-complete flag
// Revision    : 1.0 - initial release
// ============================================================================
interface program_memory_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ack;
  logic              rd_err;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;

  modport master (
    output rd_req, rd_addr, ld_start, ld_valid, ld_data,
    input  rd_data, rd_ack, rd_err, ld_ready, ld_done
  );

  modport slave (
    input  rd_req, rd_addr, ld_start, ld_valid, ld_data,
    output rd_data, rd_ack, rd_err, ld_ready, ld_done
  );
endinterface
`default_nettype wire

// File: rtl/program_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : program_memory_unit
// Description : Memory-side responder for the CPU MAR->MBR fetch path. Serves
//               CPU reads over a 4-phase req/ack handshake with WAIT_STATES
//               extra cycles, and accepts a sequential DEPTH-word program load
//               from a byte-stream writer. Sole owner of program memory.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active-high
//               bus  - slave modport of program_memory_unit_if (read + load)
// Revision    : 1.0 - initial release
// ============================================================================
module program_memory_unit #(
  parameter int DEPTH       = 9,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  program_memory_unit_if.slave       bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [3:0]        wait_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_ack_q;
  logic              rd_err_q;
  logic              ld_ready_q;
  logic              ld_done_q;

  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_word;

  // Only the low index bits address the array; the full latched address
  // decides whether the access is legal.
  assign w_in_range = (addr_q < ADDR_W'(DEPTH));
  assign w_rd_word  = w_in_range ? mem_q[addr_q[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      rd_ack_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // A load request takes priority over a simultaneous CPU read.
          if (bus.ld_start) begin
            state_q    <= S_LOAD;
            wr_ptr_q   <= '0;
            ld_done_q  <= 1'b0;
            ld_ready_q <= 1'b1;
          end else if (bus.rd_req) begin
            state_q    <= S_WAIT;
            addr_q     <= bus.rd_addr;
            wait_cnt_q <= 4'(WAIT_STATES);
          end
        end

        S_LOAD: begin
          if (bus.ld_start) begin
            wr_ptr_q <= '0;
          end else if (bus.ld_valid && ld_ready_q) begin
            mem_q[wr_ptr_q] <= bus.ld_data;
            if (wr_ptr_q == IDX_W'(DEPTH - 1)) begin
              state_q    <= S_IDLE;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
              wr_ptr_q   <= '0;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end

        S_RESP: begin
          // First RESP cycle raises ack; it then holds until the CPU drops
          // its request. rd_data is left untouched on the way out.
          if (rd_ack_q && !bus.rd_req) begin
            state_q  <= S_IDLE;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
          end else begin
            rd_ack_q  <= 1'b1;
            rd_data_q <= w_rd_word;
            rd_err_q  <= !w_in_range;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;

endmodule
`default_nettype wire

// File: tb/tb_program_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_memory_unit
// Description : Scoreboard bench for program_memory_unit. Drivers push the
//               expected read response into a queue; a monitor pops and
//               compares on every rising rd_ack. Memory contents are tracked
//               by a plain array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_memory_unit;

  localparam int DEPTH  = 9;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int WS     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_memory_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  program_memory_unit #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] new_bytes [DEPTH];
  exp_t       exp_q [$];
  bit         loading = 1'b0;
  bit         ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model_read(input logic [7:0] a);
    exp_t e;
    if (a < DEPTH) begin
      e.data = model[a];
      e.err  = 1'b0;
    end else begin
      e.data = 8'h00;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Monitor: compare every fresh acknowledge against the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rd_ack === 1'b1 && !ack_prev) begin
      check("ack_while_loading", {31'd0, loading}, 32'd0);
      check("scoreboard_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rd_data", {24'd0, bus.rd_data}, {24'd0, e.data});
        check("rd_err", {31'd0, bus.rd_err}, {31'd0, e.err});
      end
    end
    ack_prev = (bus.rd_ack === 1'b1);
  end

  task automatic wait_ack(input logic level, input string name);
    int cnt = 0;
    while (bus.rd_ack !== level && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, {31'd0, bus.rd_ack}, {31'd0, level});
  endtask

  task automatic do_read(input logic [7:0] a, input bit chk_lat);
    exp_t e;
    int   cnt = 0;
    e = model_read(a);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    while (bus.rd_ack !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) bus.rd_addr = 8'($urandom);  // must not affect the latched address
    end
    check("ack_rise", {31'd0, bus.rd_ack}, 32'd1);
    if (chk_lat) check("ack_latency", cnt, WS + 3);
    repeat (2) begin @(posedge clk); #1; end
    check("ack_held", {31'd0, bus.rd_ack}, 32'd1);
    bus.rd_req = 1'b0;
    wait_ack(1'b0, "ack_drop");
    check("err_after_drop", {31'd0, bus.rd_err}, 32'd0);
    check("data_retained", {24'd0, bus.rd_data}, {24'd0, e.data});
  endtask

  // rd_mode: 0 = no read, 1 = read raised with ld_start, 2 = read raised mid-load.
  task automatic do_load(input bit gaps, input int rd_mode, input logic [7:0] ra,
                         input int nwrites);
    int idx = 0, guard = 0, ready_cycles = 0;
    exp_t e;
    @(posedge clk); #1;
    bus.ld_start = 1'b1;
    if (rd_mode != 0) begin
      // A full load overwrites every word, so the read must see new_bytes.
      e.data = (ra < DEPTH) ? new_bytes[ra] : 8'h00;
      e.err  = (ra >= DEPTH);
      exp_q.push_back(e);
    end
    if (rd_mode == 1) begin
      bus.rd_addr = ra;
      bus.rd_req  = 1'b1;
    end
    loading = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    while (idx < nwrites && guard < 400) begin
      bus.ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.ld_data  = new_bytes[idx];
      if (rd_mode == 2 && guard == 3) begin
        bus.rd_addr = ra;
        bus.rd_req  = 1'b1;
      end
      if (bus.ld_ready === 1'b1) ready_cycles++;
      if (bus.ld_valid && bus.ld_ready === 1'b1) begin
        model[idx] = new_bytes[idx];
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.ld_valid = 1'b0;
    check("load_progress", idx, nwrites);
    if (nwrites == DEPTH) begin
      loading = 1'b0;
      check("ld_done_set", {31'd0, bus.ld_done}, 32'd1);
      check("ld_ready_clear", {31'd0, bus.ld_ready}, 32'd0);
      if (!gaps) check("ld_ready_cycles", ready_cycles, DEPTH);
    end
    if (rd_mode != 0) begin
      wait_ack(1'b1, "deferred_ack");
      bus.rd_req = 1'b0;
      wait_ack(1'b0, "deferred_ack_drop");
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_ack"},   {31'd0, bus.rd_ack},   32'd0);
    check({tag, "_rd_err"},   {31'd0, bus.rd_err},   32'd0);
    check({tag, "_rd_data"},  {24'd0, bus.rd_data},  32'd0);
    check({tag, "_ld_ready"}, {31'd0, bus.ld_ready}, 32'd0);
    check({tag, "_ld_done"},  {31'd0, bus.ld_done},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // Back-to-back load of 0x10..0x18.
    for (int i = 0; i < DEPTH; i++) new_bytes[i] = 8'h10 + 8'(i);
    do_load(1'b0, 0, 8'h00, DEPTH);

    do_read(8'd3, 1'b1);
    do_read(8'd9, 1'b1);
    do_read(8'hFF, 1'b0);
    for (int i = 0; i < 10; i++) do_read(8'($urandom_range(0, 11)), 1'b0);

    // Read raised mid-load, with ld_valid gaps.
    for (int i = 0; i < DEPTH; i++) new_bytes[i] = 8'($urandom);
    do_load(1'b1, 2, 8'($urandom_range(0, DEPTH - 1)), DEPTH);

    // Read raised in the same cycle as ld_start.
    for (int i = 0; i < DEPTH; i++) new_bytes[i] = 8'($urandom);
    do_load(1'b1, 1, 8'($urandom_range(0, DEPTH - 1)), DEPTH);
    for (int i = 0; i < 4; i++) do_read(8'($urandom_range(0, DEPTH - 1)), 1'b0);

    // Reset after 4 of 9 writes wipes memory and flags.
    for (int i = 0; i < DEPTH; i++) new_bytes[i] = 8'($urandom_range(1, 255));
    do_load(1'b0, 0, 8'h00, 4);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_load_reset");
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    loading = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_read(8'(i), 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
